mem_responder: RTL and testbench

Memory-side responder for the p18240 processor memory bus. Sits on the other end of the datapath's `memAddr`/`dataBus`/`re_L`/`we_L` interface and services word reads and writes from an internal storage array. Adds programmable wait states and reports completion with a one-cycle `rdy` pulse. Flags illegal or out-of-range accesses with a sticky `busErr` flag.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_array.sv | 26 ++
 rtl/tridrive.sv | 12 +
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the p18240 memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } memState_t;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } memOp_t;

  localparam int unsigned MEM_DATA_W   = 16;
  localparam logic [15:0] MEM_ERR_DATA = 16'h0000;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, combinational read.
// Contents are not initialised and survive reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [MEM_DATA_W-1:0] wdata,
  output logic [MEM_DATA_W-1:0] rdata
);

  logic [MEM_DATA_W-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

  // Commit a write on the clock edge.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/tridrive.sv
// Tri-state bus driver: drives the bus when enabled, releases it otherwise.
module tridrive #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  inout  tri   [WIDTH-1:0] bus
);

  assign bus = en ? din : {WIDTH{1'bz}};

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the p18240 bus: latches a request, waits
// WAIT_CYCLES, then completes it with a one-cycle rdy pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] memAddr,
  inout  tri   [15:0] dataBus,
  input  logic        re_L,
  input  logic        we_L,
  output logic        rdy,
  output logic        busy,
  output logic        busErr
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  memState_t   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  memOp_t      op_q, op_d;
  logic [15:0] data_q, data_d;
  logic        err_q, err_d;

  logic        rd_req, wr_req, both_req;
  logic        in_range;
  logic        mem_we;
  logic        drive_en;
  logic [15:0] rdata;
  logic [15:0] drive_data;

  assign rd_req   = ~re_L & we_L;
  assign wr_req   = re_L & ~we_L;
  assign both_req = ~re_L & ~we_L;

  // Any set bit above the array index makes the latched address illegal.
  assign in_range = (addr_q >> DEPTH_LOG2) == 16'd0;

  // Next-state logic for the FSM, wait counter, latches and error flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_d    = op_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (both_req) begin
          err_d = 1'b1;
        end else if (rd_req || wr_req) begin
          addr_d  = memAddr;
          op_d    = wr_req ? MEM_WR : MEM_RD;
          if (wr_req) begin
            data_d = dataBus;
          end
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_LOAD == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (!in_range) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wins over everything on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'd0;
      op_q    <= MEM_RD;
      data_q  <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // A reset on the RESP edge aborts the write, so it gates the commit.
  assign mem_we = (state_q == RESP) && (op_q == MEM_WR) && in_range && !reset;

  mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clock(clock),
    .we   (mem_we),
    .addr (addr_q[DEPTH_LOG2-1:0]),
    .wdata(data_q),
    .rdata(rdata)
  );

  assign drive_en   = (state_q == RESP) && (op_q == MEM_RD);
  assign drive_data = in_range ? rdata : MEM_ERR_DATA;

  tridrive #(
    .WIDTH(16)
  ) u_drive (
    .en (drive_en),
    .din(drive_data),
    .bus(dataBus)
  );

  assign rdy    = (state_q == RESP);
  assign busy   = (state_q != IDLE);
  assign busErr = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_CYCLES 1, 0, 3) share one
// directed stimulus stream; each has its own bus and a per-cycle reference model.
module tb_mem_responder;

  localparam int NI = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] memAddr;
  logic        re_L, we_L;
  logic [15:0] tb_data;
  logic        tb_en;
  logic        chk_on = 1'b0;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int mark_edge = 0;

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt++;

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h at %0t", name, idx, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int unsigned W = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);

    wire  [15:0] bus;
    logic        rdy, busy, busErr;

    assign bus = tb_en ? tb_data : 16'hzzzz;
    pullup pu (bus);

    mem_responder #(
      .DEPTH_LOG2 (10),
      .WAIT_CYCLES(W)
    ) dut (
      .clock  (clock),
      .reset  (reset),
      .memAddr(memAddr),
      .dataBus(bus),
      .re_L   (re_L),
      .we_L   (we_L),
      .rdy    (rdy),
      .busy   (busy),
      .busErr (busErr)
    );

    // Reference model: one access in flight, tracked by the edge it was accepted on.
    logic [15:0] mmem [int];
    bit          pend = 1'b0;
    bit          m_err = 1'b0;
    bit          m_wr = 1'b0;
    int          acc = 0;
    int          e = 0;
    logic [15:0] m_addr = 16'd0;
    logic [15:0] m_data = 16'd0;
    bit          x_rdy = 1'b0, x_busy = 1'b0, x_drive = 1'b0;
    logic [15:0] x_data = 16'd0;

    always @(posedge clock) begin
      e++;
      if (reset) begin
        pend  = 1'b0;
        m_err = 1'b0;
      end else if (pend) begin
        if (e == acc + int'(W) + 1) begin
          if (m_addr >= 16'h0400) m_err = 1'b1;
          else if (m_wr) mmem[int'(m_addr)] = m_data;
          pend = 1'b0;
        end
      end else if (!re_L && !we_L) begin
        m_err = 1'b1;
      end else if (!re_L || !we_L) begin
        pend   = 1'b1;
        acc    = e;
        m_wr   = !we_L;
        m_addr = memAddr;
        m_data = tb_data;
      end
      x_busy  = pend;
      x_rdy   = pend && (e == acc + int'(W));
      x_drive = x_rdy && !m_wr;
      if (m_addr >= 16'h0400) x_data = 16'h0000;
      else if (mmem.exists(int'(m_addr))) x_data = mmem[int'(m_addr)];
      else x_data = 16'hxxxx;
    end

    int          rdy_cnt = 0;
    int          lat = 0;
    int          run = 0;
    int          last_run = 0;
    logic [15:0] rd_val = 16'd0;

    // Per-cycle compare against the model, plus observations for literal checks.
    always @(negedge clock) begin
      if (chk_on) begin
        check("rdy", gi, 16'(rdy), 16'(x_rdy));
        check("busy", gi, 16'(busy), 16'(x_busy));
        check("busErr", gi, 16'(busErr), 16'(m_err));
        if (x_drive) check("bus_data", gi, bus, x_data);
        else if (!tb_en) check("bus_released", gi, bus, 16'hFFFF);
        if (rdy) begin
          rdy_cnt++;
          lat    = edge_cnt - mark_edge + 1;
          rd_val = bus;
        end
        if (busy) run++;
        else if (run > 0) begin
          last_run = run;
          run      = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    re_L  = 1'b1;
    we_L  = 1'b1;
    tb_en = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    memAddr = a;
    tb_data = d;
    tb_en   = 1'b1;
    we_L    = 1'b0;
    step();
    mark_edge = edge_cnt;
    we_L  = 1'b1;
    tb_en = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a);
    memAddr = a;
    re_L    = 1'b0;
    step();
    mark_edge = edge_cnt;
    re_L = 1'b1;
  endtask

  int c0, c1, c2;

  initial begin
    reset   = 1'b1;
    re_L    = 1'b1;
    we_L    = 1'b1;
    memAddr = 16'd0;
    tb_data = 16'd0;
    tb_en   = 1'b0;
    repeat (3) step();
    chk_on = 1'b1;
    reset  = 1'b0;
    idle(2);
    check("lit_reset_rdy", 0, 16'(g_dut[0].rdy), 16'd0);
    check("lit_reset_busy", 0, 16'(g_dut[0].busy), 16'd0);
    check("lit_reset_err", 0, 16'(g_dut[0].busErr), 16'd0);

    // Write then read.
    do_write(16'h0010, 16'hBEEF);
    idle(8);
    check("lit_wr_lat", 0, 16'(g_dut[0].lat), 16'd2);
    do_read(16'h0010);
    idle(8);
    check("lit_rd_data", 0, g_dut[0].rd_val, 16'hBEEF);
    check("lit_rd_lat", 0, 16'(g_dut[0].lat), 16'd2);
    check("lit_rd_lat", 2, 16'(g_dut[2].lat), 16'd4);
    check("lit_busy_len", 0, 16'(g_dut[0].last_run), 16'd2);

    // Zero wait states.
    do_write(16'h0003, 16'h1234);
    idle(8);
    do_read(16'h0003);
    idle(8);
    check("lit_zw_data", 1, g_dut[1].rd_val, 16'h1234);
    check("lit_zw_lat", 1, 16'(g_dut[1].lat), 16'd1);
    check("lit_zw_busy_len", 1, 16'(g_dut[1].last_run), 16'd1);

    // Both strobes low.
    c0 = g_dut[0].rdy_cnt;
    re_L = 1'b0;
    we_L = 1'b0;
    step();
    idle(4);
    check("lit_both_err", 0, 16'(g_dut[0].busErr), 16'd1);
    check("lit_both_nordy", 0, 16'(g_dut[0].rdy_cnt - c0), 16'd0);
    do_read(16'h0010);
    idle(8);
    check("lit_after_err_rd", 0, g_dut[0].rd_val, 16'hBEEF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(2);
    check("lit_err_cleared", 0, 16'(g_dut[0].busErr), 16'd0);

    // Out of range.
    do_write(16'h0000, 16'h0F0F);
    idle(8);
    do_write(16'h0400, 16'h5555);
    idle(8);
    check("lit_oor_err", 0, 16'(g_dut[0].busErr), 16'd1);
    do_read(16'h0400);
    idle(8);
    check("lit_oor_rd", 0, g_dut[0].rd_val, 16'h0000);
    do_read(16'h0000);
    idle(8);
    check("lit_addr0_kept", 0, g_dut[0].rd_val, 16'h0F0F);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(2);

    // Reset during the wait of a write.
    do_write(16'h0005, 16'h1111);
    idle(8);
    c2 = g_dut[2].rdy_cnt;
    do_write(16'h0005, 16'hAAAA);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(6);
    check("lit_rst_nordy", 2, 16'(g_dut[2].rdy_cnt - c2), 16'd0);
    check("lit_rst_busy", 2, 16'(g_dut[2].busy), 16'd0);
    do_read(16'h0005);
    idle(8);
    check("lit_rst_rd", 2, g_dut[2].rd_val, 16'h1111);
    check("lit_rst_rd", 0, g_dut[0].rd_val, 16'h1111);
    check("lit_rst_rd", 1, g_dut[1].rd_val, 16'hAAAA);

    // Held read strobe.
    c0 = g_dut[0].rdy_cnt;
    c1 = g_dut[1].rdy_cnt;
    memAddr = 16'h0010;
    re_L = 1'b0;
    repeat (6) step();
    check("lit_held_cnt", 0, 16'(g_dut[0].rdy_cnt - c0), 16'd2);
    check("lit_held_cnt", 1, 16'(g_dut[1].rdy_cnt - c1), 16'd3);
    check("lit_held_rd", 0, g_dut[0].rd_val, 16'hBEEF);
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
